// File: rtl/riscv_pkg.sv
// Shared decode constants: immediate format codes and the legal datapath widths.
// Consumed by imm_extract and imm_gen_pipe.
package riscv_pkg;

    localparam logic [2:0] IMM_I   = 3'b000;
    localparam logic [2:0] IMM_S   = 3'b001;
    localparam logic [2:0] IMM_B   = 3'b010;
    localparam logic [2:0] IMM_J   = 3'b011;
    localparam logic [2:0] IMM_U   = 3'b100;
    localparam logic [2:0] IMM_Z   = 3'b101;
    localparam logic [2:0] IMM_SH  = 3'b110;
    localparam logic [2:0] IMM_RSV = 3'b111;

    localparam int XLEN_RV32 = 32;
    localparam int XLEN_RV64 = 64;

    function automatic bit xlen_legal(input int xlen);
        return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
    endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction from instr[31:7] for all formats.
// The illegal output exists only when IMMGEN_ILLEGAL_CHK_EN is defined.
module imm_extract
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [24:0]     instr,
    input  logic [2:0]      src,
    output logic [XLEN-1:0] imm
`ifdef IMMGEN_ILLEGAL_CHK_EN
    ,
    output logic            illegal
`endif
);

    // Index with real instruction bit numbers to keep the field maps readable.
    logic [31:7] i;
    assign i = instr;

    logic signed [11:0] i_raw;
    logic signed [11:0] s_raw;
    logic signed [12:0] b_raw;
    logic signed [20:0] j_raw;
    logic signed [31:0] u_raw;
    logic               bad;

    assign i_raw = i[31:20];
    assign s_raw = {i[31:25], i[11:7]};
    assign b_raw = {i[31], i[7], i[30:25], i[11:8], 1'b0};
    assign j_raw = {i[31], i[19:12], i[20], i[30:21], 1'b0};
    assign u_raw = {i[31:12], 12'b0};

    always_comb begin
        imm = '0;
        bad = 1'b0;
        case (src)
            IMM_I:  imm = XLEN'(i_raw);
            IMM_S:  imm = XLEN'(s_raw);
            IMM_B:  imm = XLEN'(b_raw);
            IMM_J:  imm = XLEN'(j_raw);
            IMM_U:  imm = XLEN'(u_raw);
            IMM_Z:  imm = XLEN'(i[19:15]);
            IMM_SH: begin
                if (XLEN == XLEN_RV64) begin
                    imm = XLEN'(i[25:20]);
                end else if (i[25]) begin
                    // shamt[5] set is meaningless on RV32
                    bad = 1'b1;
                end else begin
                    imm = XLEN'(i[24:20]);
                end
            end
            default: bad = 1'b1;
        endcase
    end

`ifdef IMMGEN_ILLEGAL_CHK_EN
    assign illegal = bad;
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a 1-entry skid buffer.
// Optional IMMGEN_ILLEGAL_CHK_EN adds the registered out_illegal flag.
module imm_gen_pipe
    import riscv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_instr,
    input  logic [2:0]       in_imm_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [TAG_W-1:0] out_tag
`ifdef IMMGEN_ILLEGAL_CHK_EN
    ,
    output logic             out_illegal
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
    // The producer holds its payload until that edge; ready never depends on valid.

    if (!xlen_legal(XLEN)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0]  ext_imm;
    logic             skid_valid;
    logic [XLEN-1:0]  skid_imm;
    logic [TAG_W-1:0] skid_tag;
    logic             accept;
`ifdef IMMGEN_ILLEGAL_CHK_EN
    logic             ext_illegal;
    logic             skid_illegal;
`endif

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr   (in_instr),
        .src     (in_imm_src),
        .imm     (ext_imm)
`ifdef IMMGEN_ILLEGAL_CHK_EN
        ,
        .illegal (ext_illegal)
`endif
    );

    assign in_ready = rst & ~skid_valid;
    assign accept   = in_valid & in_ready;

    // Priority: reset, then flush, then output advance / skid capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid  <= 1'b0;
            out_imm    <= '0;
            out_tag    <= '0;
            skid_valid <= 1'b0;
            skid_imm   <= '0;
            skid_tag   <= '0;
`ifdef IMMGEN_ILLEGAL_CHK_EN
            out_illegal  <= 1'b0;
            skid_illegal <= 1'b0;
`endif
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_imm    <= skid_imm;
                out_tag    <= skid_tag;
                skid_valid <= 1'b0;
`ifdef IMMGEN_ILLEGAL_CHK_EN
                out_illegal <= skid_illegal;
`endif
            end else if (accept) begin
                out_valid <= 1'b1;
                out_imm   <= ext_imm;
                out_tag   <= in_tag;
`ifdef IMMGEN_ILLEGAL_CHK_EN
                out_illegal <= ext_illegal;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Output is stalled: park the new entry so decode need not hold it.
            skid_valid <= 1'b1;
            skid_imm   <= ext_imm;
            skid_tag   <= in_tag;
`ifdef IMMGEN_ILLEGAL_CHK_EN
            skid_illegal <= ext_illegal;
`endif
        end
    end

endmodule
